branch_resolve_queue: RTL
=========================

# branch_resolve_queue

In-order tracker for in-flight conditional branches, directly downstream of the global-history branch predictor. Each fetched branch is pushed with its PC and the predictor's taken/not-taken bit. Execute resolves branches oldest-first. On each resolution the block issues one registered `update_en`/`update_val` pulse back to the predictor's training port and flags mispredictions to the fetch redirect logic. On a mispredict, all younger in-flight entries are squashed.

## Interface
- `DEPTH`, default 4: queue entries; power of two, ≥2.
- `CNT_W`, default 16: width of the mispredict counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; asserted when 0 at a rising edge.
- `push_val`  in  1  fetch presents a predicted branch.
- `push_pc`  in  32  branch PC.
- `push_taken`  in  1  predictor output for this branch.
- `push_rdy`  out  1  entry available; equals not-full.
- `resolve_val`  in  1  execute resolves the oldest branch.
- `resolve_taken`  in  1  actual outcome.
- `resolve_rdy`  out  1  equals not-empty.
- `flush`  in  1  external squash of all entries.
- `update_en`  out  1  one-cycle training strobe to the predictor.
- `update_val`  out  1  actual outcome accompanying `update_en`.
- `mispredict`  out  1  one-cycle strobe, aligned with `update_en`.
- `mispredict_pc`  out  32  PC of the mispredicted branch; valid while `mispredict`=1.
- `count`  out  $clog2(DEPTH+1)  occupied entries.
- `mispredict_cnt`  out  CNT_W  saturating total of mispredictions.

## Operation
- Push fires when `push_val && push_rdy`: writes {pc, taken} at the tail, and the tail advances.
- Resolve fires when `resolve_val && resolve_rdy`: reads the head, and the head advances. `resolve_val` while empty is ignored.
- Mismatch: a resolve fire with `resolve_taken != head.taken`. Squash: mismatch or `flush`.
- There is no bypass. A push into an empty queue cannot resolve in the same cycle. A push to a full queue is refused even if a resolve fires in that cycle.
- Push and resolve fire together with no squash: both take effect and `count` is unchanged.
- Squash cycle:
  - All entries, including the head, are cleared next edge; head = tail = 0 and count = 0.
  - A same-cycle push fire is dropped.
  - A same-cycle resolve fire still produces its update and mispredict outputs.
- Pointers wrap modulo DEPTH. Full and empty are derived from `count`.
- `mispredict_cnt` increments on each mismatch and holds at 2^CNT_W−1.
- Reset (reset=0 at an edge):
  - count=0, pointers=0, `mispredict_cnt`=0.
  - `update_en`=0, `update_val`=0, `mispredict`=0, `mispredict_pc`=0.
  - Reset dominates all other inputs, including mid-operation. Entry contents are don't-care.

## Timing
- `push_rdy` and `resolve_rdy` are combinational from `count` only. There is no combinational path from any input to any output.
- `update_en`, `update_val`, `mispredict` and `mispredict_pc` are registered and appear the cycle after the resolve fire. Each is a single-cycle pulse.
- Latency from push to earliest resolve: 1 cycle.
- Back-to-back resolves give back-to-back `update_en` pulses, one per cycle.
- `count` reflects the pointer state after the previous edge.

## Structure
- Shared package `branch_resolve_pkg` contains:
  - typedef `br_entry_t` {logic [31:0] pc; logic taken;}.
  - localparam for the PC width.
- Sub-module `branch_resolve_fifo`: circular buffer with push, pop, clear, count and full/empty.
- Top-level logic in this block:
  - mismatch compare.
  - squash generation.
  - output registers.
  - saturating counter.

## Test plan
- Reset, then push PC 0x100 taken=1, then resolve taken=1 → `update_en`=1, `update_val`=1 and `mispredict`=0 one cycle later; count returns 0.
- Push 4 entries with DEPTH=4 → `push_rdy`=0; a 5th push is refused. Push and resolve in the same cycle while full → push refused, count=3.
- Push 0x200 (taken=0), 0x204 and 0x208, then resolve 0x200 taken=1 → next cycle `mispredict`=1, `mispredict_pc`=0x200, `mispredict_cnt`=1, count=0.
- Mismatch resolve in the same cycle as a push_val → push dropped, count=0; with 1 entry, push and a matching resolve together → count stays 1.
- Force `mispredict_cnt` toward its limit with CNT_W=2 and run 5 mispredicts → counter holds at 3.
- Assert reset=0 with 3 entries present and resolve_val=1 → `update_en`=0 next cycle, count=0, all outputs at their reset values.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolve queue.
//   PC_W        : width of a branch PC.
//   br_entry_t  : one in-flight branch, its PC and the predicted direction.
package branch_resolve_pkg;

    localparam int PC_W = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } br_entry_t;

endpackage

// File: rtl/branch_resolve_fifo.sv
// Circular buffer holding in-flight branches in program order.
// Ports:
//   clk, reset  : clock; synchronous active-low reset of pointers/count.
//   i_push      : write i_wdata at the tail (ignored when full).
//   i_wdata     : entry to write.
//   i_pop       : retire the head entry (ignored when empty).
//   i_clear     : drop every entry; dominates push and pop.
//   o_head      : entry at the head.
//   o_count     : number of occupied entries.
//   o_full      : count == DEPTH.
//   o_empty     : count == 0.
module branch_resolve_fifo
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  br_entry_t                  i_wdata,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output br_entry_t                  o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    br_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CW-1:0]      r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_head];
    assign o_count   = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_tail <= r_tail + PTR_W'(1);
            if (w_pop_ok)  r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    // Entry storage carries no reset; contents are only read when occupied.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) r_mem[r_tail] <= i_wdata;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker of predicted conditional branches. Resolves oldest-first,
// emits a registered training pulse to the predictor and flags mispredicts;
// a mispredict or flush squashes every in-flight entry.
// Ports:
//   clk, reset            : clock; synchronous active-low reset.
//   push_val/pc/taken     : fetch pushes a predicted branch; push_rdy = not full.
//   resolve_val/taken     : execute resolves the head; resolve_rdy = not empty.
//   flush                 : external squash of all entries.
//   update_en/update_val  : one-cycle training strobe with actual outcome.
//   mispredict/_pc        : one-cycle mispredict strobe and the branch PC.
//   count                 : occupied entries.
//   mispredict_cnt        : saturating mispredict total.
module branch_resolve_queue
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_val,
    input  logic [PC_W-1:0]            push_pc,
    input  logic                       push_taken,
    output logic                       push_rdy,
    input  logic                       resolve_val,
    input  logic                       resolve_taken,
    output logic                       resolve_rdy,
    input  logic                       flush,
    output logic                       update_en,
    output logic                       update_val,
    output logic                       mispredict,
    output logic [PC_W-1:0]            mispredict_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           mispredict_cnt
);

    br_entry_t        w_wdata;
    br_entry_t        w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push_fire;
    logic             w_res_fire;
    logic             w_mismatch;
    logic             w_squash;

    logic             r_update_en;
    logic             r_update_val;
    logic             r_mispredict;
    logic [PC_W-1:0]  r_mispredict_pc;
    logic [CNT_W-1:0] r_mcnt;

    assign w_wdata.pc    = push_pc;
    assign w_wdata.taken = push_taken;

    assign push_rdy    = !w_full;
    assign resolve_rdy = !w_empty;

    assign w_push_fire = push_val && !w_full;
    assign w_res_fire  = resolve_val && !w_empty;
    assign w_mismatch  = w_res_fire && (resolve_taken != w_head.taken);
    assign w_squash    = w_mismatch || flush;

    // A squash clears the whole buffer, so a same-cycle push is dropped.
    branch_resolve_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_fire && !w_squash),
        .i_wdata (w_wdata),
        .i_pop   (w_res_fire),
        .i_clear (w_squash),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Resolution outputs, registered one cycle after the resolve fire.
    // All are zero outside their pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_update_en     <= 1'b0;
            r_update_val    <= 1'b0;
            r_mispredict    <= 1'b0;
            r_mispredict_pc <= '0;
            r_mcnt          <= '0;
        end else begin
            r_update_en     <= w_res_fire;
            r_update_val    <= w_res_fire && resolve_taken;
            r_mispredict    <= w_mismatch;
            r_mispredict_pc <= w_mismatch ? w_head.pc : '0;
            if (w_mismatch && (r_mcnt != '1)) r_mcnt <= r_mcnt + CNT_W'(1);
        end
    end

    assign update_en      = r_update_en;
    assign update_val     = r_update_val;
    assign mispredict     = r_mispredict;
    assign mispredict_pc  = r_mispredict_pc;
    assign mispredict_cnt = r_mcnt;

endmodule
